// File: rtl/johnson_seq_pkg.sv
// Shared state encoding and default geometry for the Johnson phase sequencer.
package johnson_seq_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_LAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/johnson_ring.sv
// WIDTH-bit Johnson ring register with synchronous clear/enable and a legal-state check.
module johnson_ring
    import johnson_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             legal
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    int unsigned      edges;

    always_comb begin
        dout_d = dout_q;
        if (clr) begin
            dout_d = '0;
        end else if (en) begin
            dout_d = {dout_q[WIDTH-2:0], ~dout_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // A legal Johnson word has at most one 0/1 boundary between adjacent bits.
    always_comb begin
        edges = 0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            edges = edges + {31'b0, dout_q[i] ^ dout_q[i+1]};
        end
        legal = (edges <= 1);
    end

    assign dout = dout_q;

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Run-controlled lap sequencer over a Johnson ring: FSM, lap counter, phase decode, error flag.
module johnson_phase_sequencer
    import johnson_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LAP_W = DEF_LAP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LAP_W-1:0]   laps,
    input  logic               hold,
    input  logic               abort,
    output logic [WIDTH-1:0]   dout,
    output logic [2*WIDTH-1:0] phase,
    output logic [LAP_W-1:0]   lap_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [WIDTH-1:0] LAST_STATE = {1'b1, {(WIDTH-1){1'b0}}};

    seq_state_t         state_q, state_d;
    logic [LAP_W-1:0]   laps_q, laps_d;
    logic [LAP_W-1:0]   lap_q, lap_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] phase_q, phase_d;
    logic               ring_en, ring_clr, ring_legal;
    logic [WIDTH-1:0]   ring_val, ring_nxt;

    function automatic logic [2*WIDTH-1:0] phase_of(input logic [WIDTH-1:0] v);
        int unsigned pop;
        int unsigned k;
        pop = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + {31'b0, v[i]};
        end
        k = v[WIDTH-1] ? (2 * WIDTH - pop) : pop;
        return (2*WIDTH)'(1) << k;
    endfunction

    johnson_ring #(
        .WIDTH(WIDTH)
    ) u_ring (
        .clk  (clk),
        .reset(reset),
        .en   (ring_en),
        .clr  (ring_clr),
        .dout (ring_val),
        .legal(ring_legal)
    );

    always_comb begin
        state_d  = state_q;
        laps_d   = laps_q;
        lap_d    = lap_q;
        err_d    = err_q;
        ring_en  = 1'b0;
        ring_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (laps != '0)) begin
                    laps_d   = laps;
                    lap_d    = '0;
                    err_d    = 1'b0;
                    ring_clr = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Illegal-word recovery outranks hold so a corrupted ring never stays frozen.
                if (abort) begin
                    ring_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!ring_legal) begin
                    err_d    = 1'b1;
                    ring_clr = 1'b1;
                end else if (!hold) begin
                    ring_en = 1'b1;
                    if (ring_val == LAST_STATE) begin
                        lap_d = lap_q + 1'b1;
                        if (lap_d == laps_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                ring_clr = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                ring_clr = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Phase is registered alongside the ring, so decode the ring's next value.
    always_comb begin
        ring_nxt = ring_val;
        if (ring_clr) begin
            ring_nxt = '0;
        end else if (ring_en) begin
            ring_nxt = {ring_val[WIDTH-2:0], ~ring_val[WIDTH-1]};
        end
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        phase_d = busy_d ? phase_of(ring_nxt) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            laps_q  <= '0;
            lap_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            laps_q  <= laps_d;
            lap_q   <= lap_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
        end
    end

    assign dout    = ring_val;
    assign phase   = phase_q;
    assign lap_cnt = lap_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed bench for johnson_phase_sequencer with a per-cycle expected-value scoreboard.
module tb_johnson_phase_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned LW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   laps;
    logic            hold;
    logic            abort;
    logic [W-1:0]    dout;
    logic [2*W-1:0]  phase;
    logic [LW-1:0]   lap_cnt;
    logic            busy;
    logic            done;
    logic            err;

    typedef struct {
        logic [W-1:0]   dout;
        logic [2*W-1:0] phase;
        logic [LW-1:0]  lap;
        logic           busy;
        logic           done;
        logic           err;
    } exp_t;

    exp_t sb[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          busy_cycles;
    int          done_pulses;

    int unsigned mstate;
    int unsigned midx;
    logic [LW-1:0] mlap;
    logic [LW-1:0] mlaps;
    logic          merr;

    johnson_phase_sequencer #(
        .WIDTH(W),
        .LAP_W(LW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .laps   (laps),
        .hold   (hold),
        .abort  (abort),
        .dout   (dout),
        .phase  (phase),
        .lap_cnt(lap_cnt),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ring_of(input int unsigned k);
        if (k <= W) return W'((1 << k) - 1);
        return W'(~((1 << (k - W)) - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mstate = 0;
        midx   = 0;
        mlap   = '0;
        merr   = 1'b0;
    endtask

    task automatic model_step(input bit ill);
        case (mstate)
            0: if (start && laps != 0) begin
                mlaps  = laps;
                mlap   = '0;
                merr   = 1'b0;
                midx   = 0;
                mstate = 1;
            end
            1: if (abort) begin
                mstate = 0;
                midx   = 0;
            end else if (ill) begin
                merr = 1'b1;
                midx = 0;
            end else if (!hold) begin
                if (midx == 2 * W - 1) begin
                    midx = 0;
                    mlap = mlap + 8'd1;
                    if (mlap == mlaps) mstate = 2;
                end else begin
                    midx = midx + 1;
                end
            end
            default: mstate = 0;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.dout  = ring_of(midx);
        e.phase = (mstate == 1) ? (2*W)'(1 << midx) : '0;
        e.lap   = mlap;
        e.busy  = (mstate == 1);
        e.done  = (mstate == 2);
        e.err   = merr;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e.dout));
        chk("phase", 32'(phase), 32'(e.phase));
        chk("lap_cnt", 32'(lap_cnt), 32'(e.lap));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("err", 32'(err), 32'(e.err));
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_pulses++;
    endtask

    task automatic step(input bit ill);
        model_step(ill);
        push_exp();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < 400 && mstate != 0; i++) step(1'b0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        laps  = '0;
        hold  = 1'b0;
        abort = 1'b0;
        model_reset();
        #2;
        push_exp();
        check_out();
        #10 reset = 1'b1;

        // Single lap
        busy_cycles = 0;
        done_pulses = 0;
        start = 1'b1;
        laps  = 8'd1;
        step(1'b0);
        start = 1'b0;
        laps  = 8'hxx;
        run_to_idle();
        chk("single_busy_len", busy_cycles, 8);
        chk("single_done_cnt", done_pulses, 1);
        chk("single_lap_cnt", 32'(lap_cnt), 1);

        // Three laps with a four-cycle hold at 0011
        busy_cycles = 0;
        done_pulses = 0;
        start = 1'b1;
        laps  = 8'd3;
        step(1'b0);
        start = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("hold_entry_dout", 32'(dout), 32'h3);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);
        chk("hold_dout_frozen", 32'(dout), 32'h3);
        hold = 1'b0;
        run_to_idle();
        chk("hold_busy_len", busy_cycles, 28);
        chk("hold_done_cnt", done_pulses, 1);
        chk("hold_lap_cnt", 32'(lap_cnt), 3);

        // Abort at lap 2 / 1110, then ignored starts
        done_pulses = 0;
        start = 1'b1;
        laps  = 8'd5;
        step(1'b0);
        start = 1'b0;
        for (int i = 0; i < 100 && !(mlap == 2 && midx == 5); i++) step(1'b0);
        chk("abort_at_dout", 32'(dout), 32'he);
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_lap_cnt", 32'(lap_cnt), 2);
        start = 1'b1;
        laps  = 8'd0;
        step(1'b0);
        start = 1'b0;
        step(1'b0);
        chk("zero_laps_idle", 32'(busy), 0);
        start = 1'b1;
        laps  = 8'd2;
        step(1'b0);
        laps  = 8'd7;
        for (int i = 0; i < 3; i++) step(1'b0);
        start = 1'b0;
        run_to_idle();
        chk("abort_done_cnt", done_pulses, 1);
        chk("busy_start_lap_cnt", 32'(lap_cnt), 2);

        // Illegal ring value injected mid-run
        start = 1'b1;
        laps  = 8'd2;
        step(1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        force dut.u_ring.dout_q = 4'b0101;
        #3;
        release dut.u_ring.dout_q;
        step(1'b1);
        chk("illegal_err", 32'(err), 1);
        chk("illegal_dout", 32'(dout), 0);
        run_to_idle();
        chk("illegal_lap_cnt", 32'(lap_cnt), 2);
        chk("err_sticky_idle", 32'(err), 1);
        start = 1'b1;
        laps  = 8'd2;
        step(1'b0);
        start = 1'b0;
        chk("err_cleared", 32'(err), 0);

        // Asynchronous reset while dout=0111
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("pre_reset_dout", 32'(dout), 32'h7);
        done_pulses = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        push_exp();
        check_out();
        chk("reset_no_done", done_pulses, 0);
        #2 reset = 1'b1;
        step(1'b0);
        step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
